// File: rtl/ntt_agen.sv
// ntt_agen: in-place radix-2 forward NTT address generator; optional cycle counter via NTT_AGEN_PERF_CNT_EN.
// Revision 1.0
`default_nettype none

module ntt_agen #(
  parameter int N          = 256,
  parameter int BF_LATENCY = 4,
  parameter int AW         = $clog2(N),
  parameter int LOGN       = $clog2(N),
  parameter int TW         = LOGN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [TW-1:0] tw_idx,
  output logic          bf_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b,
  output logic [31:0]   cycle_count
);

  localparam int SW = $clog2(LOGN);
  localparam int PW = LOGN - 1;
  localparam int D  = BF_LATENCY + 1;

  localparam logic [PW-1:0] P_LAST = PW'(N/2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);
  localparam logic [D-1:0]  TOP    = D'(1) << (D - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state, state_n;
  logic [SW-1:0] s, s_n;
  logic [PW-1:0] p, p_n;
  logic [D-1:0]  v_pipe;
  logic [AW-1:0] a_pipe [D];
  logic [AW-1:0] b_pipe [D];
  logic          last_wr;

  // Address math on the pair index: len = N>>(s+1) is a power of two.
  logic [SW-1:0]   sh;
  logic [LOGN-1:0] p_ext, len, g, o, addr_a, addr_b, tw;

  always_comb begin
    sh     = S_LAST - s;
    p_ext  = {1'b0, p};
    len    = LOGN'(1) << sh;
    g      = p_ext >> sh;
    o      = p_ext & (len - LOGN'(1));
    addr_a = ((g << sh) << 1) | o;
    addr_b = addr_a | len;
    tw     = (LOGN'(1) << s) | g;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      p     <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      p     <= p_n;
    end
  end

  // The stage ends on the cycle its last write-back leaves the delay line.
  assign last_wr = v_pipe[D-1] && ((v_pipe & ~TOP) == '0);

  always_comb begin
    state_n = state;
    s_n     = s;
    p_n     = p;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          s_n     = '0;
          p_n     = '0;
        end
      end
      ISSUE: begin
        if (p == P_LAST) begin
          state_n = DRAIN;
          p_n     = '0;
        end else begin
          p_n = p + PW'(1);
        end
      end
      DRAIN: begin
        if (last_wr) begin
          if (s == S_LAST) begin
            state_n = DONE;
            s_n     = '0;
          end else begin
            state_n = ISSUE;
            s_n     = s + SW'(1);
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == ISSUE) || (state == DRAIN);
  assign done      = (state == DONE);
  assign rd_en     = (state == ISSUE);
  assign rd_addr_a = rd_en ? AW'(addr_a) : '0;
  assign rd_addr_b = rd_en ? AW'(addr_b) : '0;
  assign tw_idx    = rd_en ? TW'(tw) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
      for (int i = 0; i < D; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0] <= rd_en;
      a_pipe[0] <= rd_addr_a;
      b_pipe[0] <= rd_addr_b;
      for (int i = 1; i < D; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        a_pipe[i] <= a_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
      end
    end
  end

  assign bf_valid  = v_pipe[0];
  assign wr_en     = v_pipe[D-1];
  assign wr_addr_a = a_pipe[D-1];
  assign wr_addr_b = b_pipe[D-1];

`ifdef NTT_AGEN_PERF_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == IDLE) && start) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign cycle_count = cnt;
`else
  assign cycle_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/ntt_agen.md
NTT_AGEN -- requirements
Module: ntt_agen

Interface
- REQ-001: Parameter N, default 256; transform length, power of two, 4..1024.
- REQ-002: Parameter BF_LATENCY, default 4; cycles from butterfly input to butterfly output.
- REQ-003: Parameter AW, default $clog2(N); coefficient address width.
- REQ-004: Derived LOGN = $clog2(N); twiddle index width TW = LOGN.
- REQ-005: clk  input  1  single clock; all logic on rising edge.
- REQ-006: rst  input  1  reset, synchronous, active-high.
- REQ-007: start  input  1  one-cycle request to run a full forward NTT.
- REQ-008: busy  output  1  transform in progress.
- REQ-009: done  output  1  one-cycle pulse after the final write-back.
- REQ-010: rd_en  output  1  read strobe to the coefficient RAM (sync read, 1-cycle latency).
- REQ-011: rd_addr_a / rd_addr_b  output  AW each  butterfly pair addresses.
- REQ-012: tw_idx  output  TW  twiddle ROM index, valid with rd_en.
- REQ-013: bf_valid  output  1  butterfly input valid, rd_en delayed 1 cycle.
- REQ-014: wr_en  output  1  write strobe for butterfly a_out/b_out.
- REQ-015: wr_addr_a / wr_addr_b  output  AW each  write-back addresses.
- REQ-016: cycle_count  output  32  busy-cycle count of the last or current run.

Function
- REQ-017: FSM states are IDLE, ISSUE, DRAIN and DONE.
- REQ-018: IDLE: start=1 -> ISSUE; stage s=0, pair p=0; busy=1 from the next cycle.
- REQ-019: ISSUE, each cycle: rd_en=1, issue pair p of stage s.
- REQ-020: Pair mapping: len = N>>(s+1), g = p/len, o = p mod len, rd_addr_a = 2*g*len+o, rd_addr_b = rd_addr_a+len, tw_idx = 2^s+g.
- REQ-021: ISSUE, p = N/2-1: -> DRAIN, p := 0.
- REQ-022: DRAIN: rd_en=0; wait until the cycle of the final wr_en of stage s.
- REQ-023: DRAIN exit, s < LOGN-1: s := s+1, -> ISSUE next cycle.
- REQ-024: DRAIN exit, s = LOGN-1: -> DONE.
- REQ-025: Stages never overlap; this is the read-after-write guarantee.
- REQ-026: DONE: done=1 and busy=0 for exactly one cycle, then -> IDLE.
- REQ-027: bf_valid equals rd_en delayed 1 cycle.
- REQ-028: wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed 1+BF_LATENCY cycles, via a shift-register delay line.
- REQ-029: Per-stage period is N/2+BF_LATENCY+1 cycles: first rd_en at cycle c, last wr_en at c+N/2+BF_LATENCY.
- REQ-030: start while busy or in DONE is ignored, with no restart or queuing.
- REQ-031: start in IDLE coincident with done of a prior run is impossible; DONE always returns to IDLE first.
- REQ-032: Addresses, tw_idx and counters are unsigned; no wrap beyond N-1 or N/2-1.

Reset
- REQ-033: rst=1 forces IDLE; busy, done, rd_en, bf_valid and wr_en go to 0; all addresses, tw_idx, s and p go to 0; the delay line clears; cycle_count goes to 0.
- REQ-034: rst mid-run discards all in-flight writes; no wr_en is produced after rst deasserts until a new start.

Configuration
- REQ-035: Macro NTT_AGEN_PERF_CNT_EN defined: cycle_count clears on accepted start, increments every cycle busy=1, and holds after done.
- REQ-036: Macro NTT_AGEN_PERF_CNT_EN undefined: cycle_count is tied to 0 and no counter is synthesized.

Verification (N=8, BF_LATENCY=4, macro defined; start sampled at cycle 0)
- REQ-037: Stage 0: rd_en at cycles 1-4, pairs (0,4),(1,5),(2,6),(3,7), tw_idx=1; matching wr_en at cycles 6-9.
- REQ-038: Stage 1: rd_en at cycles 10-13, pairs (0,2),(1,3),(4,6),(5,7), tw_idx 2,2,3,3. Stage 2: rd_en at cycles 19-22, pairs (0,1),(2,3),(4,5),(6,7), tw_idx 4,5,6,7.
- REQ-039: Final wr_en at cycle 27; done=1 only at cycle 28; busy high for cycles 1-27; cycle_count=27 afterwards.
- REQ-040: start re-pulsed at cycles 5 and 15 -> no change to the sequence or to the done cycle.
- REQ-041: rst=1 at cycle 8 for one cycle -> outputs 0 at cycle 9; no wr_en through cycle 40; a new start then gives the REQ-037 sequence.
- REQ-042: Macro undefined, same run -> identical address and strobe trace; cycle_count=0 throughout.
